if_fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch stage. Decouples PC generation from decode with an instruction queue and supports a pipelined SRAM-like read port with multiple outstanding requests. Applies branch redirects with full flush and discard of in-flight responses. Sits between the branch unit/`ID_Unit` and the instruction-memory bridge.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_sync_fifo.sv | 57 +++++
 rtl/if_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared widths, default reset PC and redirect state encoding for the fetch queue.
package if_pkg;

    localparam int          IF_TO_ID_BUS_W   = 64;
    localparam int          BR_BUS_W         = 33;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } redir_state_e;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; registered storage, head read from the array.
module if_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int          CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with PC-tag FIFO, instruction queue and branch redirect/discard.
// Optional IF_FQ_BYPASS_EN: a live response reaching an empty queue is presented to ID combinationally.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BR_BUS_W-1:0]       br_bus,
    input  logic                      id_allow_in,
    output logic                      if_to_id_valid,
    output logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus,
    output logic                      inst_sram_req,
    output logic [31:0]               inst_sram_addr,
    input  logic                      inst_sram_addr_ok,
    input  logic                      inst_sram_data_ok,
    input  logic [31:0]               inst_sram_rdata
);

    localparam int TAG_CW = $clog2(MAX_OUT + 1);
    localparam int Q_CW   = $clog2(FQ_DEPTH + 1);
    localparam int SUM_W  = ((Q_CW > TAG_CW) ? Q_CW : TAG_CW) + 1;

    redir_state_e state_q;
    logic [31:0]  fetch_pc_q, redir_pc_q;
    logic [TAG_CW-1:0] discard_q, discard_d;
    logic         run_q;

    logic              br_taken;
    logic [31:0]       br_target;
    logic              accept, credit_ok;
    logic [TAG_CW-1:0] inflight, inflight_live, inflight_nxt;
    logic [SUM_W-1:0]  occupancy;
    logic [31:0]       tag_head;
    logic              tag_empty, tag_pop;
    logic [Q_CW-1:0]   q_cnt;
    logic              q_empty, q_push, q_pop, rsp_live;
    logic [IF_TO_ID_BUS_W-1:0] rsp_entry, q_head;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Credits: never hold more live instructions than the queue can absorb.
    assign inflight_live = inflight - discard_q;
    assign occupancy     = SUM_W'(q_cnt) + SUM_W'(inflight_live);
    assign credit_ok     = (inflight < TAG_CW'(MAX_OUT)) && (occupancy < SUM_W'(FQ_DEPTH));

    // run_q keeps req low for the reset cycle itself.
    assign inst_sram_req  = run_q & ((state_q == HOLD) | credit_ok);
    assign inst_sram_addr = fetch_pc_q;
    assign accept         = inst_sram_req & inst_sram_addr_ok;

    assign tag_pop      = inst_sram_data_ok & ~tag_empty;
    assign inflight_nxt = inflight + TAG_CW'(accept) - TAG_CW'(tag_pop);

    // A response in a redirect cycle is wrong-path even when nothing is marked yet.
    assign rsp_live  = tag_pop & (discard_q == '0) & ~br_taken;
    assign rsp_entry = {tag_head, inst_sram_rdata};
    assign q_pop     = ~q_empty & id_allow_in;

`ifdef IF_FQ_BYPASS_EN
    logic byp;
    assign byp            = rsp_live & q_empty;
    assign q_push         = rsp_live & ~(byp & id_allow_in);
    assign if_to_id_valid = ~q_empty | byp;
    assign if_to_id_bus   = byp ? rsp_entry : q_head;
`else
    assign q_push         = rsp_live;
    assign if_to_id_valid = ~q_empty;
    assign if_to_id_bus   = q_head;
`endif

    always_comb begin
        discard_d = discard_q;
        if (tag_pop && discard_q != '0) discard_d = discard_q - 1'b1;
        if (state_q == HOLD && accept)  discard_d = discard_d + 1'b1;
        if (state_q == RUN && br_taken) discard_d = inflight_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            discard_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            discard_q <= discard_d;
            case (state_q)
                RUN: begin
                    if (br_taken) begin
                        if (inst_sram_req && !inst_sram_addr_ok) begin
                            redir_pc_q <= br_target;
                            state_q    <= HOLD;
                        end else begin
                            fetch_pc_q <= br_target;
                        end
                    end else if (accept) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        fetch_pc_q <= br_taken ? br_target : redir_pc_q;
                        state_q    <= RUN;
                    end else if (br_taken) begin
                        redir_pc_q <= br_target;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    if_sync_fifo #(
        .WIDTH(32),
        .DEPTH(MAX_OUT),
        .CNT_W(TAG_CW)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (reset),
        .flush_i(1'b0),
        .push_i (accept),
        .wdata_i(fetch_pc_q),
        .pop_i  (tag_pop),
        .rdata_o(tag_head),
        .empty_o(tag_empty),
        .count_o(inflight)
    );

    if_sync_fifo #(
        .WIDTH(IF_TO_ID_BUS_W),
        .DEPTH(FQ_DEPTH),
        .CNT_W(Q_CW)
    ) u_inst_queue (
        .clk    (clk),
        .rst    (reset),
        .flush_i(br_taken),
        .push_i (q_push),
        .wdata_i(rsp_entry),
        .pop_i  (q_pop),
        .rdata_o(q_head),
        .empty_o(q_empty),
        .count_o(q_cnt)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: request/response model drives expectations, monitor checks ID side.
`timescale 1ns/1ps
module tb_if_fetch_queue;

    localparam int          FQ_DEPTH = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RPC      = 32'h1c00_0000;
`ifdef IF_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic [32:0] br_bus = '0;
    logic        id_allow_in = 1'b0;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    if_fetch_queue #(.FQ_DEPTH(FQ_DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_bus           (br_bus),
        .id_allow_in      (id_allow_in),
        .if_to_id_valid   (if_to_id_valid),
        .if_to_id_bus     (if_to_id_bus),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(addr_ok),
        .inst_sram_data_ok(data_ok),
        .inst_sram_rdata  (rdata)
    );

    typedef struct { logic [31:0] pc; bit stale; } out_t;
    out_t        outq[$];
    logic [63:0] expq[$];
    logic [31:0] exp_pc, redir_pc, prev_addr, cap_pc;
    bit          pend_stale, chk_empty, prev_stall, cap_en;
    int          errors = 0, checks = 0, npop = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h0f0f_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ID handshake pops the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (chk_empty) check("valid_after_br", {63'd0, if_to_id_valid}, 64'd0);
            if (if_to_id_valid && id_allow_in) begin
                npop++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected: got %h expected no entry", if_to_id_bus);
                end else begin
                    logic [63:0] e;
                    e = expq.pop_front();
                    check("id_bus", if_to_id_bus, e);
                    if (cap_en) begin
                        cap_pc = e[63:32];
                        cap_en = 1'b0;
                    end
                end
            end
        end
    end

    // One clock of stimulus plus the spec-level request/redirect model.
    task automatic cyc(input bit aok, input bit dok_en, input bit allow, input bit br, input logic [31:0] tgt);
        out_t o;
        @(posedge clk); #1;
        addr_ok     = aok;
        id_allow_in = allow;
        br_bus      = {br, tgt};
        data_ok     = dok_en && (outq.size() > 0);
        rdata       = '0;
        if (data_ok) begin
            o     = outq.pop_front();
            rdata = inst_of(o.pc);
            if (!o.stale && !br) expq.push_back({o.pc, rdata});
        end
        @(negedge clk); #1;
        if (prev_stall) begin
            check("req_held", {63'd0, inst_sram_req}, 64'd1);
            check("addr_held", {32'd0, inst_sram_addr}, {32'd0, prev_addr});
        end
        prev_stall = inst_sram_req && !addr_ok;
        prev_addr  = inst_sram_addr;
        if (inst_sram_req && addr_ok) begin
            check("req_addr", {32'd0, inst_sram_addr}, {32'd0, exp_pc});
            outq.push_back('{pc: exp_pc, stale: br || pend_stale});
            if (outq.size() > MAX_OUT) check("max_out", 64'(outq.size()), 64'(MAX_OUT));
            if (pend_stale) begin
                exp_pc     = redir_pc;
                pend_stale = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (expq.size() > FQ_DEPTH) check("queue_bound", 64'(expq.size()), 64'(FQ_DEPTH));
        if (br) begin
            expq.delete();
            foreach (outq[i]) outq[i].stale = 1'b1;
            if (inst_sram_req && !addr_ok) begin
                pend_stale = 1'b1;
                redir_pc   = tgt;
            end else begin
                exp_pc = tgt;
            end
        end
        chk_empty = br;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        addr_ok = 1'b0; data_ok = 1'b0; id_allow_in = 1'b0; br_bus = '0; rdata = '0;
        @(negedge clk);
        check("rst_req", {63'd0, inst_sram_req}, 64'd0);
        check("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
        check("rst_bus", if_to_id_bus, 64'd0);
        check("rst_addr", {32'd0, inst_sram_addr}, {32'd0, RPC});
        outq.delete(); expq.delete();
        exp_pc = RPC; pend_stale = 1'b0; chk_empty = 1'b0; prev_stall = 1'b0; cap_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n0;
        logic [31:0] t;
        do_reset();

        // Back-to-back handshakes from reset; latency and throughput.
        cyc(1, 1, 1, 0, 0);
        check("first_req", {63'd0, inst_sram_req}, 64'd1);
        cyc(1, 1, 1, 0, 0);
        check("lat_same_cycle", {63'd0, if_to_id_valid}, {63'd0, BYP});
        cyc(1, 1, 1, 0, 0);
        check("lat_next_cycle", {63'd0, if_to_id_valid}, 64'd1);
        n0 = npop;
        repeat (16) cyc(1, 1, 1, 0, 0);
        check("throughput", 64'(npop - n0), 64'd16);

        // ID stalled: queue fills to depth, requests stop.
        repeat (20) cyc(1, 1, 0, 0, 0);
        check("stall_req_off", {63'd0, inst_sram_req}, 64'd0);
        check("stall_queue", 64'(expq.size()), 64'(FQ_DEPTH));
        check("stall_inflight", 64'(outq.size()), 64'd0);
        repeat (10) cyc(1, 1, 1, 0, 0);

        // Redirect with two responses in flight.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("two_inflight", 64'(outq.size()), 64'd2);
        cyc(1, 0, 1, 1, 32'h1c00_0100);
        cap_en = 1'b1;
        repeat (10) cyc(1, 1, 1, 0, 0);
        check("br_target_pc", {32'd0, cap_pc}, {32'd0, 32'h1c00_0100});

        // Redirect while the request is stalled.
        cyc(0, 1, 1, 1, 32'h1c00_0100);
        check("stall_br_req", {63'd0, inst_sram_req}, 64'd1);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cap_en = 1'b1;
        repeat (10) cyc(1, 1, 1, 0, 0);
        check("held_br_pc", {32'd0, cap_pc}, {32'd0, 32'h1c00_0100});

        // Redirect coinciding with both addr_ok and data_ok.
        cyc(1, 1, 1, 1, 32'h1c00_0300);
        check("same_cycle_dok", {63'd0, data_ok}, 64'd1);
        cap_en = 1'b1;
        repeat (10) cyc(1, 1, 1, 0, 0);
        check("same_cycle_pc", {32'd0, cap_pc}, {32'd0, 32'h1c00_0300});

        // Randomised traffic, including redirects near the top of the address space.
        repeat (3000) begin
            t = $urandom();
            t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t = 32'hffff_fff8;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, t);
        end

        // Reset mid-operation, then resume.
        do_reset();
        repeat (20) cyc(1, 1, 1, 0, 0);

        // Drain without new requests being accepted.
        repeat (10) cyc(0, 1, 1, 0, 0);
        check("drain_empty", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
